stereo_ram_arbiter: RTL

Shares a single frame-buffer RAM write port between the two MIPI receive chains (left and right camera) of the stereo system. It accepts each receiver's 32-bit pixel word, its line-relative write address and its write strobe, and buffers them per camera in a small FIFO. It grants the RAM port round-robin and maps each word into a per-camera ping-pong bank. It sits between the two receiver instances and the frame-buffer RAM/SDRAM write interface.

---
 rtl/stereo_arb_pkg.sv | 27 ++
 rtl/stereo_arb_fifo.sv | 54 +++++
 rtl/stereo_ram_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/stereo_arb_pkg.sv
// Shared types and helpers for the stereo frame-buffer write arbiter.
// Entries carry a camera-relative address sized for the widest supported RAM (32-bit address).
package stereo_arb_pkg;

    localparam int CAM0           = 0;
    localparam int CAM1           = 1;
    localparam int CAM_ADDR_MAX_W = 30;
    localparam int PIX_W          = 32;

    typedef struct packed {
        logic                      bank;
        logic [CAM_ADDR_MAX_W-1:0] addr;
        logic [PIX_W-1:0]          data;
    } entry_t;

    // Builds {cam, bank, addr} for a RAM of addr_w bits; the caller truncates to addr_w.
    function automatic logic [31:0] map_addr(input logic                      cam,
                                             input logic                      bank,
                                             input logic [CAM_ADDR_MAX_W-1:0] addr,
                                             input int                        addr_w);
        logic [31:0] full_addr;
        full_addr = {2'b00, addr} & ((32'd1 << (addr_w - 2)) - 32'd1);
        full_addr = full_addr | (32'(cam) << (addr_w - 1)) | (32'(bank) << (addr_w - 2));
        return full_addr;
    endfunction

endpackage

// File: rtl/stereo_arb_fifo.sv
// Synchronous FIFO with registered fill count; pop data is read combinationally from the head.
// Latency: a word pushed at edge N is visible on pop_dat after edge N.
// Backpressure: a push while full is ignored unless a pop frees the slot in the same cycle.
module stereo_arb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Pointers run modulo 2*DEPTH so the extra MSB separates full from empty.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (count == '0);
    assign do_pop  = pop_rdy && !empty;
    assign do_push = push_vld && (!full || do_pop);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/stereo_ram_arbiter.sv
// Round-robin arbiter sharing one frame-buffer RAM write port between left/right MIPI receivers.
// Latency: push in cycle N reaches ram_we/ram_addr/ram_data in cycle N+2 when the path is idle.
// Backpressure: output held while ram_we && !ram_ready; full FIFO drops the word and sets ovf.
// STEREO_ARB_OVF_CNT_EN adds saturating per-camera drop counters ovf_cnt0/ovf_cnt1.
module stereo_ram_arbiter
    import stereo_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [1:0]        cam_we,
    input  logic [ADDR_W-3:0] cam_addr0,
    input  logic [ADDR_W-3:0] cam_addr1,
    input  logic [31:0]       cam_data0,
    input  logic [31:0]       cam_data1,
    input  logic [1:0]        frame_start,
    input  logic              ram_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_data,
    output logic [1:0]        disp_bank,
    output logic [1:0]        ovf
`ifdef STEREO_ARB_OVF_CNT_EN
    ,
    output logic [15:0]       ovf_cnt0,
    output logic [15:0]       ovf_cnt1
`endif
);

    localparam int ENTRY_W = $bits(entry_t);

    logic [ADDR_W-3:0] cam_addr [2];
    logic [31:0]       cam_data [2];
    entry_t            push_ent [2];
    entry_t            pop_ent  [2];
    entry_t            sel_ent;
    logic [1:0]        wr_bank;
    logic [1:0]        push_vld;
    logic [1:0]        fifo_full;
    logic [1:0]        fifo_empty;
    logic [1:0]        pop_rdy;
    logic [1:0]        drop;
    logic [1:0]        req;
    logic              out_free;
    logic              gnt_vld;
    logic              gnt_cam;
    logic              last_grant;

    assign cam_addr[CAM0] = cam_addr0;
    assign cam_addr[CAM1] = cam_addr1;
    assign cam_data[CAM0] = cam_data0;
    assign cam_data[CAM1] = cam_data1;

    for (genvar c = 0; c < 2; c++) begin : g_cam
        // Bank is sampled before any same-cycle frame_start toggle lands.
        assign push_vld[c] = cam_we[c] && enable;
        assign push_ent[c] = '{bank: wr_bank[c],
                               addr: CAM_ADDR_MAX_W'(cam_addr[c]),
                               data: cam_data[c]};
        assign drop[c]     = push_vld[c] && fifo_full[c] && !pop_rdy[c];

        stereo_arb_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (ENTRY_W)
        ) u_fifo (
            .sys_clk  (sys_clk),
            .reset_n  (reset_n),
            .push_vld (push_vld[c]),
            .push_dat (push_ent[c]),
            .pop_rdy  (pop_rdy[c]),
            .pop_dat  (pop_ent[c]),
            .full     (fifo_full[c]),
            .empty    (fifo_empty[c])
        );
    end

    assign req      = ~fifo_empty;
    assign out_free = !ram_we || ram_ready;

    always_comb begin
        gnt_vld = out_free && (req != 2'b00);
        gnt_cam = 1'b0;
        if (req == 2'b11) begin
            gnt_cam = ~last_grant;
        end else if (req[CAM1]) begin
            gnt_cam = 1'b1;
        end
        pop_rdy = 2'b00;
        if (gnt_vld) pop_rdy[gnt_cam] = 1'b1;
    end

    assign sel_ent   = pop_ent[gnt_cam];
    assign disp_bank = ~wr_bank;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= '0;
            last_grant <= 1'b1;
            wr_bank    <= 2'b00;
            ovf        <= 2'b00;
        end else begin
            wr_bank <= wr_bank ^ frame_start;
            ovf     <= ovf | drop;
            if (gnt_vld) begin
                ram_we     <= 1'b1;
                ram_addr   <= ADDR_W'(map_addr(gnt_cam, sel_ent.bank, sel_ent.addr, ADDR_W));
                ram_data   <= sel_ent.data;
                last_grant <= gnt_cam;
            end else if (ram_ready) begin
                ram_we <= 1'b0;
            end
        end
    end

`ifdef STEREO_ARB_OVF_CNT_EN
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_cnt0 <= '0;
            ovf_cnt1 <= '0;
        end else begin
            if (drop[CAM0] && ovf_cnt0 != 16'hFFFF) ovf_cnt0 <= ovf_cnt0 + 16'd1;
            if (drop[CAM1] && ovf_cnt1 != 16'hFFFF) ovf_cnt1 <= ovf_cnt1 + 16'd1;
        end
    end
`else
    // Drops are reported through the sticky ovf bits only.
`endif

endmodule
